// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code encodings for the shift group
// plus the data and shift-amount widths.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ALU_SLL  = 2'b00,
    ALU_SRL  = 2'b01,
    ALU_RSVD = 2'b10,
    ALU_SRA  = 2'b11
  } alu_shift_op_e;

  localparam logic [1:0] ALU_GRP_SHIFT = 2'b10;

  // Mirror a data word so that a left shift can reuse the right-shift stages.
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_barrel.sv
// Combinational 5-stage logarithmic shifter (16,8,4,2,1). Left shifts are
// handled by mirroring the operand around a shared right-shift network.
module alu_shift_barrel
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] sh,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   y
);

  logic             left_s;
  logic             fill_s;
  logic             valid_s;
  logic [WIDTH-1:0] pre_s;
  logic [WIDTH-1:0] stg_s [0:SHAMT_W];

  // Decode direction, fill bit and whether the code is a defined shift.
  always_comb begin
    left_s  = 1'b0;
    fill_s  = 1'b0;
    valid_s = 1'b1;
    case (op)
      ALU_SLL: left_s = 1'b1;
      ALU_SRL: fill_s = 1'b0;
      ALU_SRA: fill_s = b[WIDTH-1];
      default: valid_s = 1'b0;
    endcase
  end

  always_comb begin
    if (left_s) begin
      pre_s = bit_reverse(b);
    end else begin
      pre_s = b;
    end
  end

  assign stg_s[0] = pre_s;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int AMT = 16 >> i;
    assign stg_s[i+1] = sh[SHAMT_W-1-i]
                        ? {{AMT{fill_s}}, stg_s[i][WIDTH-1:AMT]}
                        : stg_s[i];
  end

  // Undo the mirroring for left shifts; reserved code yields zero.
  always_comb begin
    if (!valid_s) begin
      y = {WIDTH{1'b0}};
    end else if (left_s) begin
      y = bit_reverse(stg_s[SHAMT_W]);
    end else begin
      y = stg_s[SHAMT_W];
    end
  end

endmodule

// File: rtl/alu_shift.sv
// Shift sub-unit of the MIPS ALU: SLL/SRL/SRA of B by A[4:0], selected by
// ALUFun[1:0], with a single registered output stage.
module alu_shift
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [5:0]        ALUFun,
  output logic [WIDTH-1:0]  S
);

  logic [WIDTH-1:0] shift_y;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;

  // Upper amount bits and the group/function prefix are decoded elsewhere.
  logic unused_s;
  assign unused_s = ^{A[WIDTH-1:SHAMT_W], ALUFun[5:2]};

  alu_shift_barrel u_barrel (
    .b  (B),
    .sh (A[SHAMT_W-1:0]),
    .op (ALUFun[1:0]),
    .y  (shift_y)
  );

  always_comb begin
    s_d = shift_y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= {WIDTH{1'b0}};
    end else begin
      s_q <= s_d;
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_alu_shift.sv
// Self-checking bench for alu_shift: directed vectors plus random traffic,
// expected results queued at drive time and popped one edge later.
module tb_alu_shift;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALUFun;
  logic [31:0] S;

  int n_vec;
  int n_err;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  alu_shift dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .ALUFun (ALUFun),
    .S      (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: S=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] f);
    logic [4:0] sh;
    sh = a[4:0];
    case (f[1:0])
      2'b00:   return b << sh;
      2'b01:   return b >> sh;
      2'b11:   return 32'($signed(b) >>> sh);
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Drive one vector at the falling edge, check it just after the next rising edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic [31:0] exp);
    @(negedge clk);
    A      = a;
    B      = b;
    ALUFun = f;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, S, exp);
    end else begin
      check_eq(tag_q.pop_front(), S, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rf;
    n_vec  = 0;
    n_err  = 0;

    // Reset asserted from time zero: output must be clear with no clock edge.
    reset  = 1'b1;
    A      = 32'd4;
    B      = 32'hFFFF_FFFF;
    ALUFun = 6'b100000;
    #1;
    check_eq("reset_async", S, 32'h0000_0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", S, 32'h0000_0000);
    end
    @(negedge clk);
    reset = 1'b0;

    apply("sll4",     32'd4, 32'hFFFF_FFFF, 6'b100000, 32'hFFFF_FFF0);
    apply("srl4",     32'd4, 32'hFFFF_FFFF, 6'b100001, 32'h0FFF_FFFF);
    apply("sra4_neg", 32'd4, 32'hFFFF_FFFF, 6'b100011, 32'hFFFF_FFFF);
    apply("sra4_pos", 32'd4, 32'h7FFF_FFFF, 6'b100011, 32'h07FF_FFFF);
    apply("sll0",     32'd0, 32'hA5C3_1E96, 6'b100000, 32'hA5C3_1E96);
    apply("srl0",     32'd0, 32'h8123_4567, 6'b100001, 32'h8123_4567);
    apply("sra0",     32'd0, 32'h8123_4567, 6'b100011, 32'h8123_4567);
    apply("sll31",    32'd31, 32'h8000_0001, 6'b100000, 32'h8000_0000);
    apply("srl31",    32'd31, 32'h8000_0001, 6'b100001, 32'h0000_0001);
    apply("sra31",    32'd31, 32'h8000_0001, 6'b100011, 32'hFFFF_FFFF);
    apply("sll_hiA",  32'hFFFF_FFE4, 32'hFFFF_FFFF, 6'b100000, 32'hFFFF_FFF0);
    apply("srl_hiA",  32'hFFFF_FFE4, 32'hFFFF_FFFF, 6'b100001, 32'h0FFF_FFFF);
    apply("rsvd",     32'd3, 32'hDEAD_BEEF, 6'b100010, 32'h0000_0000);
    apply("sll_hifun", 32'd8, 32'h0000_00AB, 6'b011100, 32'h0000_AB00);
    apply("srl16",    32'd16, 32'h1234_5678, 6'b100001, 32'h0000_1234);
    apply("sra16",    32'd16, 32'h8765_4321, 6'b100011, 32'hFFFF_8765);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 6'($urandom_range(0, 63));
      apply("rand", ra, rb, rf, ref_shift(ra, rb, rf));
    end

    // Mid-stream reset: a nonzero result must clear without waiting for an edge.
    apply("pre_rst", 32'd0, 32'h1234_5678, 6'b100000, 32'h1234_5678);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_async", S, 32'h0000_0000);
    exp_q.delete();
    tag_q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("mid_rst_hold", S, 32'h0000_0000);
    end
    @(negedge clk);
    reset = 1'b0;
    apply("post_rst", 32'd1, 32'h4000_0000, 6'b100011, 32'h2000_0000);

    for (int i = 0; i < 50; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 6'($urandom_range(0, 63));
      apply("rand2", ra, rb, rf, ref_shift(ra, rb, rf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
